// File: rtl/axi_xbar.sv
// 1-to-2 AXI4 address router: reads go to the CLINT or the SoC bus, writes go to the SoC bus,
// and writes aimed at the CLINT window are drained locally and answered with SLVERR.
module axi_xbar #(
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_W-1:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  // upstream port
  input  logic                in_arvalid,
  output logic                in_arready,
  input  logic [ID_W-1:0]     in_arid,
  input  logic [ADDR_W-1:0]   in_araddr,
  input  logic [7:0]          in_arlen,
  input  logic [2:0]          in_arsize,
  input  logic [1:0]          in_arburst,
  output logic                in_rvalid,
  input  logic                in_rready,
  output logic [ID_W-1:0]     in_rid,
  output logic [DATA_W-1:0]   in_rdata,
  output logic [1:0]          in_rresp,
  output logic                in_rlast,
  input  logic                in_awvalid,
  output logic                in_awready,
  input  logic [ID_W-1:0]     in_awid,
  input  logic [ADDR_W-1:0]   in_awaddr,
  input  logic [7:0]          in_awlen,
  input  logic [2:0]          in_awsize,
  input  logic [1:0]          in_awburst,
  input  logic                in_wvalid,
  output logic                in_wready,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  input  logic                in_wlast,
  output logic                in_bvalid,
  input  logic                in_bready,
  output logic [ID_W-1:0]     in_bid,
  output logic [1:0]          in_bresp,
  // SoC bus port
  output logic                soc_arvalid,
  input  logic                soc_arready,
  output logic [ID_W-1:0]     soc_arid,
  output logic [ADDR_W-1:0]   soc_araddr,
  output logic [7:0]          soc_arlen,
  output logic [2:0]          soc_arsize,
  output logic [1:0]          soc_arburst,
  input  logic                soc_rvalid,
  output logic                soc_rready,
  input  logic [ID_W-1:0]     soc_rid,
  input  logic [DATA_W-1:0]   soc_rdata,
  input  logic [1:0]          soc_rresp,
  input  logic                soc_rlast,
  output logic                soc_awvalid,
  input  logic                soc_awready,
  output logic [ID_W-1:0]     soc_awid,
  output logic [ADDR_W-1:0]   soc_awaddr,
  output logic [7:0]          soc_awlen,
  output logic [2:0]          soc_awsize,
  output logic [1:0]          soc_awburst,
  output logic                soc_wvalid,
  input  logic                soc_wready,
  output logic [DATA_W-1:0]   soc_wdata,
  output logic [DATA_W/8-1:0] soc_wstrb,
  output logic                soc_wlast,
  input  logic                soc_bvalid,
  output logic                soc_bready,
  input  logic [ID_W-1:0]     soc_bid,
  input  logic [1:0]          soc_bresp,
  // CLINT read-only port
  output logic                clint_arvalid,
  input  logic                clint_arready,
  output logic [ID_W-1:0]     clint_arid,
  output logic [ADDR_W-1:0]   clint_araddr,
  output logic [7:0]          clint_arlen,
  output logic [2:0]          clint_arsize,
  output logic [1:0]          clint_arburst,
  input  logic                clint_rvalid,
  output logic                clint_rready,
  input  logic [ID_W-1:0]     clint_rid,
  input  logic [DATA_W-1:0]   clint_rdata,
  input  logic [1:0]          clint_rresp,
  input  logic                clint_rlast,
  output logic                o_rbusy,
  output logic                o_wbusy
);

  typedef enum logic [1:0] {R_IDLE, R_SOC, R_CLINT} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_SOC, W_ERR_DATA, W_ERR_RESP} wstate_t;

  rstate_t         rstate, rstate_nxt;
  wstate_t         wstate, wstate_nxt;
  logic            ar_sent, aw_sent;
  logic [ID_W-1:0] err_id;
  logic            ar_hit, aw_hit;

  assign ar_hit  = (in_araddr & CLINT_MASK) == CLINT_BASE;
  assign aw_hit  = (in_awaddr & CLINT_MASK) == CLINT_BASE;
  assign o_rbusy = rstate != R_IDLE;
  assign o_wbusy = wstate != W_IDLE;

  // ar_sent/aw_sent stop a held valid from launching a second address into the same slot
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rstate  <= R_IDLE;
      wstate  <= W_IDLE;
      ar_sent <= 1'b0;
      aw_sent <= 1'b0;
      err_id  <= '0;
    end else begin
      rstate  <= rstate_nxt;
      wstate  <= wstate_nxt;
      ar_sent <= (rstate != R_IDLE) && (ar_sent || (in_arvalid && in_arready));
      aw_sent <= (wstate == W_SOC) && (aw_sent || (in_awvalid && in_awready));
      if (wstate == W_IDLE && in_awvalid) err_id <= in_awid;
    end
  end

  always_comb begin
    rstate_nxt    = rstate;
    in_arready    = 1'b0;
    in_rvalid     = 1'b0;
    in_rid        = '0;
    in_rdata      = '0;
    in_rresp      = '0;
    in_rlast      = 1'b0;
    soc_arvalid   = 1'b0;
    soc_arid      = '0;
    soc_araddr    = '0;
    soc_arlen     = '0;
    soc_arsize    = '0;
    soc_arburst   = '0;
    soc_rready    = 1'b0;
    clint_arvalid = 1'b0;
    clint_arid    = '0;
    clint_araddr  = '0;
    clint_arlen   = '0;
    clint_arsize  = '0;
    clint_arburst = '0;
    clint_rready  = 1'b0;
    case (rstate)
      R_IDLE: if (in_arvalid) rstate_nxt = ar_hit ? R_CLINT : R_SOC;
      R_SOC: begin
        soc_arvalid = in_arvalid && !ar_sent;
        soc_arid    = in_arid;
        soc_araddr  = in_araddr;
        soc_arlen   = in_arlen;
        soc_arsize  = in_arsize;
        soc_arburst = in_arburst;
        in_arready  = soc_arready && !ar_sent;
        in_rvalid   = soc_rvalid;
        in_rid      = soc_rid;
        in_rdata    = soc_rdata;
        in_rresp    = soc_rresp;
        in_rlast    = soc_rlast;
        soc_rready  = in_rready;
        if (soc_rvalid && in_rready && soc_rlast) rstate_nxt = R_IDLE;
      end
      R_CLINT: begin
        clint_arvalid = in_arvalid && !ar_sent;
        clint_arid    = in_arid;
        clint_araddr  = in_araddr;
        clint_arlen   = in_arlen;
        clint_arsize  = in_arsize;
        clint_arburst = in_arburst;
        in_arready    = clint_arready && !ar_sent;
        in_rvalid     = clint_rvalid;
        in_rid        = clint_rid;
        in_rdata      = clint_rdata;
        in_rresp      = clint_rresp;
        in_rlast      = clint_rlast;
        clint_rready  = in_rready;
        if (clint_rvalid && in_rready && clint_rlast) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_nxt  = wstate;
    in_awready  = 1'b0;
    in_wready   = 1'b0;
    in_bvalid   = 1'b0;
    in_bid      = '0;
    in_bresp    = '0;
    soc_awvalid = 1'b0;
    soc_awid    = '0;
    soc_awaddr  = '0;
    soc_awlen   = '0;
    soc_awsize  = '0;
    soc_awburst = '0;
    soc_wvalid  = 1'b0;
    soc_wdata   = '0;
    soc_wstrb   = '0;
    soc_wlast   = 1'b0;
    soc_bready  = 1'b0;
    case (wstate)
      W_IDLE: if (in_awvalid) begin
        // CLINT-window writes are accepted on the spot; the drain states answer them
        in_awready = aw_hit;
        wstate_nxt = aw_hit ? W_ERR_DATA : W_SOC;
      end
      W_SOC: begin
        soc_awvalid = in_awvalid && !aw_sent;
        soc_awid    = in_awid;
        soc_awaddr  = in_awaddr;
        soc_awlen   = in_awlen;
        soc_awsize  = in_awsize;
        soc_awburst = in_awburst;
        in_awready  = soc_awready && !aw_sent;
        soc_wvalid  = in_wvalid;
        soc_wdata   = in_wdata;
        soc_wstrb   = in_wstrb;
        soc_wlast   = in_wlast;
        in_wready   = soc_wready;
        in_bvalid   = soc_bvalid;
        in_bid      = soc_bid;
        in_bresp    = soc_bresp;
        soc_bready  = in_bready;
        if (soc_bvalid && in_bready) wstate_nxt = W_IDLE;
      end
      W_ERR_DATA: begin
        in_wready = 1'b1;
        if (in_wvalid && in_wlast) wstate_nxt = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        in_bvalid = 1'b1;
        in_bid    = err_id;
        in_bresp  = 2'b10;
        if (in_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar.sv
// Randomized scoreboard bench for axi_xbar: TB-side SoC/CLINT slave models, an upstream
// master, and a monitor that pops expected traffic whenever a handshake occurs.
module tb_axi_xbar;
  logic clk, i_reset;
  logic in_arvalid, in_arready; logic [3:0] in_arid; logic [31:0] in_araddr;
  logic [7:0] in_arlen; logic [2:0] in_arsize; logic [1:0] in_arburst;
  logic in_rvalid, in_rready; logic [3:0] in_rid; logic [31:0] in_rdata; logic [1:0] in_rresp; logic in_rlast;
  logic in_awvalid, in_awready; logic [3:0] in_awid; logic [31:0] in_awaddr;
  logic [7:0] in_awlen; logic [2:0] in_awsize; logic [1:0] in_awburst;
  logic in_wvalid, in_wready; logic [31:0] in_wdata; logic [3:0] in_wstrb; logic in_wlast;
  logic in_bvalid, in_bready; logic [3:0] in_bid; logic [1:0] in_bresp;
  logic soc_arvalid, soc_arready; logic [3:0] soc_arid; logic [31:0] soc_araddr;
  logic [7:0] soc_arlen; logic [2:0] soc_arsize; logic [1:0] soc_arburst;
  logic soc_rvalid, soc_rready; logic [3:0] soc_rid; logic [31:0] soc_rdata; logic [1:0] soc_rresp; logic soc_rlast;
  logic soc_awvalid, soc_awready; logic [3:0] soc_awid; logic [31:0] soc_awaddr;
  logic [7:0] soc_awlen; logic [2:0] soc_awsize; logic [1:0] soc_awburst;
  logic soc_wvalid, soc_wready; logic [31:0] soc_wdata; logic [3:0] soc_wstrb; logic soc_wlast;
  logic soc_bvalid, soc_bready; logic [3:0] soc_bid; logic [1:0] soc_bresp;
  logic clint_arvalid, clint_arready; logic [3:0] clint_arid; logic [31:0] clint_araddr;
  logic [7:0] clint_arlen; logic [2:0] clint_arsize; logic [1:0] clint_arburst;
  logic clint_rvalid, clint_rready; logic [3:0] clint_rid; logic [31:0] clint_rdata; logic [1:0] clint_rresp; logic clint_rlast;
  logic o_rbusy, o_wbusy;

  axi_xbar dut (
    .i_clock(clk), .i_reset(i_reset),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_arid(in_arid), .in_araddr(in_araddr),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rid(in_rid), .in_rdata(in_rdata),
    .in_rresp(in_rresp), .in_rlast(in_rlast),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awid(in_awid), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_wlast(in_wlast), .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bid(in_bid),
    .in_bresp(in_bresp),
    .soc_arvalid(soc_arvalid), .soc_arready(soc_arready), .soc_arid(soc_arid), .soc_araddr(soc_araddr),
    .soc_arlen(soc_arlen), .soc_arsize(soc_arsize), .soc_arburst(soc_arburst),
    .soc_rvalid(soc_rvalid), .soc_rready(soc_rready), .soc_rid(soc_rid), .soc_rdata(soc_rdata),
    .soc_rresp(soc_rresp), .soc_rlast(soc_rlast),
    .soc_awvalid(soc_awvalid), .soc_awready(soc_awready), .soc_awid(soc_awid), .soc_awaddr(soc_awaddr),
    .soc_awlen(soc_awlen), .soc_awsize(soc_awsize), .soc_awburst(soc_awburst),
    .soc_wvalid(soc_wvalid), .soc_wready(soc_wready), .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb),
    .soc_wlast(soc_wlast), .soc_bvalid(soc_bvalid), .soc_bready(soc_bready), .soc_bid(soc_bid),
    .soc_bresp(soc_bresp),
    .clint_arvalid(clint_arvalid), .clint_arready(clint_arready), .clint_arid(clint_arid),
    .clint_araddr(clint_araddr), .clint_arlen(clint_arlen), .clint_arsize(clint_arsize),
    .clint_arburst(clint_arburst), .clint_rvalid(clint_rvalid), .clint_rready(clint_rready),
    .clint_rid(clint_rid), .clint_rdata(clint_rdata), .clint_rresp(clint_rresp), .clint_rlast(clint_rlast),
    .o_rbusy(o_rbusy), .o_wbusy(o_wbusy)
  );

  wire any_out = |{in_arready, in_rvalid, in_rid, in_rdata, in_rresp, in_rlast, in_awready, in_wready,
                   in_bvalid, in_bid, in_bresp, soc_arvalid, soc_arid, soc_araddr, soc_arlen, soc_arsize,
                   soc_arburst, soc_rready, soc_awvalid, soc_awid, soc_awaddr, soc_awlen, soc_awsize,
                   soc_awburst, soc_wvalid, soc_wdata, soc_wstrb, soc_wlast, soc_bready, clint_arvalid,
                   clint_arid, clint_araddr, clint_arlen, clint_arsize, clint_arburst, clint_rready,
                   o_rbusy, o_wbusy};

  int n_chk = 0, n_fail = 0, rcnt = 0;
  logic [63:0] exp_r[$], exp_b[$], exp_sar[$], exp_car[$], exp_saw[$], exp_sw[$];
  logic [63:0] e_m;
  localparam logic [63:0] NONE = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #500000; $display("FAIL watchdog: simulation did not complete"); $fatal(1); end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, got, exp); end
  endtask

  task automatic tmo(input string nm);
    n_chk++; n_fail++; $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // CLINT window as an address range, independent of the mask form used by the design
  function automatic bit is_clint(input logic [31:0] a);
    return a >= 32'h0200_0000 && a < 32'h0201_0000;
  endfunction

  // read data encodes the responding slave, so misrouting shows up as a data error
  function automatic logic [31:0] rd_data(input logic [31:0] a, input logic [7:0] b, input bit c);
    return (a + 32'(b) * 4) ^ (c ? 32'hC000_0000 : 32'h3000_0000);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(3))
      0: return 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
      1: return $urandom;
      2: return 32'h0201_0000 + ($urandom & 32'hFC);
      default: return 32'h01FF_FF00 + ($urandom & 32'hFC);
    endcase
  endfunction

  // SoC read slave
  initial begin : soc_rd
    bit act, hs; logic [31:0] a; logic [7:0] n, b; logic [3:0] id;
    act = 0; a = 0; n = 0; b = 0; id = 0;
    soc_arready = 0; soc_rvalid = 0; soc_rid = 0; soc_rdata = 0; soc_rresp = 0; soc_rlast = 0;
    forever begin
      @(posedge clk);
      hs = soc_rvalid && soc_rready;
      if (i_reset) act = 0;
      else if (soc_arvalid && soc_arready) begin act = 1; a = soc_araddr; n = soc_arlen; b = 0; id = soc_arid; end
      else if (hs) begin if (b == n) act = 0; else b++; end
      @(negedge clk);
      soc_arready = !act;
      soc_rvalid  = act && ((soc_rvalid && !hs) || $urandom_range(3) != 0);
      soc_rdata   = rd_data(a, b, 0); soc_rid = id; soc_rlast = (b == n);
    end
  end

  // CLINT read slave
  initial begin : clint_rd
    bit act, hs; logic [31:0] a; logic [7:0] n, b; logic [3:0] id;
    act = 0; a = 0; n = 0; b = 0; id = 0;
    clint_arready = 0; clint_rvalid = 0; clint_rid = 0; clint_rdata = 0; clint_rresp = 0; clint_rlast = 0;
    forever begin
      @(posedge clk);
      hs = clint_rvalid && clint_rready;
      if (i_reset) act = 0;
      else if (clint_arvalid && clint_arready) begin act = 1; a = clint_araddr; n = clint_arlen; b = 0; id = clint_arid; end
      else if (hs) begin if (b == n) act = 0; else b++; end
      @(negedge clk);
      clint_arready = !act;
      clint_rvalid  = act && ((clint_rvalid && !hs) || $urandom_range(3) != 0);
      clint_rdata   = rd_data(a, b, 1); clint_rid = id; clint_rlast = (b == n);
    end
  end

  // SoC write slave: always OKAY, echoes awid
  initial begin : soc_wr
    bit act, bpend; logic [3:0] id;
    act = 0; bpend = 0; id = 0;
    soc_awready = 0; soc_wready = 0; soc_bvalid = 0; soc_bid = 0; soc_bresp = 0;
    forever begin
      @(posedge clk);
      if (i_reset) begin act = 0; bpend = 0; end
      else begin
        if (soc_awvalid && soc_awready) begin act = 1; id = soc_awid; end
        if (soc_wvalid && soc_wready && soc_wlast) bpend = 1;
        if (soc_bvalid && soc_bready) begin act = 0; bpend = 0; end
      end
      @(negedge clk);
      soc_awready = !act;
      soc_wready  = act && !bpend && ($urandom_range(2) != 0);
      soc_bvalid  = bpend; soc_bid = id;
    end
  end

  initial begin : up_ready
    in_rready = 0; in_bready = 0;
    forever begin
      @(negedge clk);
      in_rready = $urandom_range(3) != 0;
      in_bready = $urandom_range(2) != 0;
    end
  end

  // monitor: every handshake pops its expected entry
  always @(posedge clk) begin
    if (!i_reset) begin
      if (soc_arvalid || clint_arvalid) chk("ar_onehot", soc_arvalid & clint_arvalid, 0);
      if (in_rvalid && in_rready) begin
        rcnt++;
        chk("rbusy_beat", o_rbusy, 1);
        e_m = exp_r.size() != 0 ? exp_r.pop_front() : NONE;
        chk("r_beat", {in_rdata, in_rid, in_rlast}, e_m);
      end
      if (soc_arvalid && soc_arready) begin
        e_m = exp_sar.size() != 0 ? exp_sar.pop_front() : NONE;
        chk("soc_ar", {soc_araddr, soc_arlen}, e_m);
      end
      if (clint_arvalid && clint_arready) begin
        e_m = exp_car.size() != 0 ? exp_car.pop_front() : NONE;
        chk("clint_ar", {clint_araddr, clint_arlen}, e_m);
      end
      if (soc_awvalid && soc_awready) begin
        e_m = exp_saw.size() != 0 ? exp_saw.pop_front() : NONE;
        chk("soc_aw", {soc_awaddr, soc_awlen}, e_m);
      end
      if (soc_wvalid && soc_wready) begin
        e_m = exp_sw.size() != 0 ? exp_sw.pop_front() : NONE;
        chk("soc_w", {soc_wstrb, soc_wdata, soc_wlast}, e_m);
      end
      if (in_bvalid && in_bready) begin
        e_m = exp_b.size() != 0 ? exp_b.pop_front() : NONE;
        chk("b_resp", {in_bid, in_bresp}, e_m);
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    bit c; int t;
    c = is_clint(a);
    t = 0;
    while (exp_r.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) tmo("rd_prev");
    @(negedge clk);
    in_arvalid = 1; in_araddr = a; in_arlen = len; in_arid = id; in_arsize = 3'd2; in_arburst = 2'b01;
    for (int b = 0; b <= int'(len); b++) exp_r.push_back({27'b0, rd_data(a, 8'(b), c), id, b == int'(len)});
    if (c) exp_car.push_back({24'b0, a, len}); else exp_sar.push_back({24'b0, a, len});
    #1 chk("ar_grant_lat0", {soc_arvalid, clint_arvalid, in_arready}, 0);
    @(negedge clk);
    chk("ar_route", {soc_arvalid, clint_arvalid}, c ? 2'b01 : 2'b10);
    chk("rbusy_set", o_rbusy, 1);
    t = 0;
    forever begin
      @(posedge clk);
      if (in_arready) break;
      if (++t > 200) begin tmo("arready"); break; end
    end
    @(negedge clk);
    in_arvalid = 0; in_araddr = $urandom;
  endtask

  task automatic do_write(input logic [31:0] a, input int nb, input logic [3:0] id);
    bit c; int t;
    c = is_clint(a);
    t = 0;
    while (exp_b.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) tmo("wr_prev");
    @(negedge clk);
    in_awvalid = 1; in_awaddr = a; in_awid = id; in_awlen = 8'(nb - 1); in_awsize = 3'd2; in_awburst = 2'b01;
    exp_b.push_back({58'b0, id, c ? 2'b10 : 2'b00});
    if (!c) exp_saw.push_back({24'b0, a, 8'(nb - 1)});
    #1 chk("aw_accept_now", in_awready, c);
    t = 0;
    forever begin
      @(posedge clk);
      if (in_awready) break;
      if (++t > 200) begin tmo("awready"); break; end
    end
    @(negedge clk);
    in_awvalid = 0; in_awaddr = $urandom;
    for (int i = 0; i < nb; i++) begin
      in_wvalid = 1; in_wdata = $urandom; in_wstrb = 4'($urandom); in_wlast = (i == nb - 1);
      if (!c) exp_sw.push_back({27'b0, in_wstrb, in_wdata, in_wlast});
      t = 0;
      forever begin
        @(posedge clk);
        if (in_wready) break;
        if (++t > 200) begin tmo("wready"); break; end
      end
      @(negedge clk);
    end
    in_wvalid = 0; in_wlast = 0;
  endtask

  task automatic wait_rd_done();
    int t = 0;
    while (exp_r.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) tmo("rd_done"); else chk("rbusy_clear", o_rbusy, 0);
  endtask

  task automatic wait_wr_done();
    int t = 0;
    while (exp_b.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) tmo("wr_done"); else chk("wbusy_clear", o_wbusy, 0);
  endtask

  initial begin
    int r0, t;
    i_reset = 1;
    in_arvalid = 0; in_arid = 0; in_araddr = 0; in_arlen = 0; in_arsize = 0; in_arburst = 0;
    in_awvalid = 0; in_awid = 0; in_awaddr = 0; in_awlen = 0; in_awsize = 0; in_awburst = 0;
    in_wvalid = 0; in_wdata = 0; in_wstrb = 0; in_wlast = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", any_out, 0);
    i_reset = 0;
    @(negedge clk);
    chk("idle_outs", any_out, 0);

    do_read(32'h0200_BFF8, 0, 4'h1); wait_rd_done();        // CLINT single beat
    do_read(32'h8000_0000, 3, 4'h2); wait_rd_done();        // 4-beat SoC burst
    do_write(32'h0200_0000, 2, 4'h5); wait_wr_done();       // CLINT write -> SLVERR
    fork                                                    // parallel read + write
      do_read(32'h0200_0010, 1, 4'h3);
      do_write(32'h1000_0000, 3, 4'h6);
    join
    wait_rd_done(); wait_wr_done();
    do_read(32'h01FF_FFFF, 0, 4'h9); do_read(32'h0201_0000, 1, 4'hA);
    do_read(32'h0200_FFFC, 0, 4'hB); wait_rd_done();
    do_write(32'h01FF_FFFF, 1, 4'hC); do_write(32'h0201_0000, 2, 4'hD);
    do_write(32'h0200_FFFC, 1, 4'hE); wait_wr_done();

    fork
      for (int i = 0; i < 30; i++) do_read(pick_addr(), 8'($urandom_range(3)), 4'($urandom));
      for (int j = 0; j < 30; j++) do_write(pick_addr(), $urandom_range(1, 4), 4'($urandom));
    join
    wait_rd_done(); wait_wr_done();

    // reset during the second beat of a SoC burst
    do_read(32'h8000_0040, 3, 4'h7);
    r0 = rcnt; t = 0;
    while (rcnt == r0 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) tmo("first_beat");
    i_reset = 1;
    @(posedge clk); #1;
    chk("rst_rbusy", o_rbusy, 0);
    chk("rst_outs", any_out, 0);
    @(negedge clk);
    i_reset = 0;
    exp_r.delete(); exp_sar.delete(); exp_car.delete();
    do_read(32'h8000_0100, 1, 4'h8); wait_rd_done();

    chk("queues_empty", exp_r.size() + exp_b.size() + exp_sar.size() + exp_car.size()
                        + exp_saw.size() + exp_sw.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
